gcd_sequencer: RTL and testbench

- Microsequencer that computes the unsigned 16-bit GCD of two operands using the shared alu_regfile datapath (subtractive Euclid).
- Drives the datapath's control ports: a_reg, b_reg, dest_reg, immediate, immediate_p and alu_op.
- Reads back alu_bus and flags, and presents a start/busy/done handshake to the host.
- Replaces the free-running fib_machine-style driver with a handshaked, terminating controller.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_regfile.sv | 56 +++++
 rtl/gcd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_gcd_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_regfile datapath and its microsequencers:
// opcodes, flag bit positions and the GCD sequencer state encoding.
package alu_pkg;

  localparam logic [7:0] OP_MOV = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_CMP = 8'h03;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LD_A = 3'd1,
    ST_LD_B = 3'd2,
    ST_CMP  = 3'd3,
    ST_STEP = 3'd4,
    ST_FIN  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Eight-entry register file with a single ALU; alu_bus is written back into
// dest_reg every cycle and the ALU flags are registered on the same edge.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        a_reg,
  input  logic [2:0]        b_reg,
  input  logic [2:0]        dest_reg,
  input  logic [DATA_W-1:0] immediate,
  input  logic              immediate_p,
  input  logic [7:0]        alu_op,
  output logic [DATA_W-1:0] alu_bus,
  output logic [4:0]        flags
);

  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] a_val;
  logic [DATA_W-1:0] b_val;
  logic [4:0]        flags_d;
  logic [4:0]        flags_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    a_val   = regs_q[a_reg];
    b_val   = immediate_p ? immediate : regs_q[b_reg];
    alu_bus = '0;
    flags_d = '0;
    unique case (alu_op)
      OP_MOV:         alu_bus = b_val;
      OP_SUB, OP_CMP: alu_bus = a_val - b_val;
      default:        alu_bus = '0;
    endcase
    flags_d[FLAG_Z] = (alu_op == OP_CMP) ? (a_val == b_val) : (alu_bus == '0);
    flags_d[FLAG_L] = (alu_op == OP_CMP || alu_op == OP_SUB) && (a_val < b_val);
    flags_d[FLAG_C] = (alu_op == OP_SUB) && (a_val < b_val);
    flags_d[FLAG_N] = alu_bus[DATA_W-1];
  end

  // NOTE: the register array carries no reset; its contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    regs_q[dest_reg] <= alu_bus;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= '0;
    else       flags_q <= flags_d;
  end

  assign flags = flags_q;

endmodule

// File: rtl/gcd_sequencer.sv
// Handshaked microsequencer computing gcd(op_a, op_b) by subtractive Euclid
// on the shared alu_regfile datapath; aborts with err after MAX_ITER steps.
module gcd_sequencer
  import alu_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter logic [2:0]  RA       = 3'd1,
  parameter logic [2:0]  RB       = 3'd2,
  parameter logic [2:0]  RSCR     = 3'd7,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              err,
  output logic [2:0]        a_reg,
  output logic [2:0]        b_reg,
  output logic [2:0]        dest_reg,
  output logic [DATA_W-1:0] immediate,
  output logic              immediate_p,
  output logic [7:0]        alu_op,
  input  logic [DATA_W-1:0] alu_bus,
  input  logic [4:0]        flags
);

  localparam logic [15:0] MAX_ITER_C = 16'(MAX_ITER);

  seq_state_e        state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic flag_z;
  logic flag_l;
  logic at_limit;
  logic unused_flags;

  assign flag_z       = flags[FLAG_Z];
  assign flag_l       = flags[FLAG_L];
  assign at_limit     = (cnt_q == MAX_ITER_C);
  assign unused_flags = ^{flags[FLAG_C], flags[FLAG_F], flags[FLAG_N]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (op_a == '0 || op_b == '0) begin
            // gcd(x,0) = x and gcd(0,0) = 0, so no datapath work is needed.
            result_d = op_a | op_b;
            state_d  = ST_FIN;
          end else begin
            a_d     = op_a;
            b_d     = op_b;
            cnt_d   = '0;
            state_d = ST_LD_A;
          end
        end
      end
      ST_LD_A: state_d = ST_LD_B;
      ST_LD_B: state_d = ST_CMP;
      ST_CMP:  state_d = ST_STEP;
      ST_STEP: begin
        if (flag_z) begin
          result_d = alu_bus;
          state_d  = ST_FIN;
        end else if (at_limit) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = ST_FIN;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = ST_CMP;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    a_reg       = RSCR;
    b_reg       = RSCR;
    dest_reg    = RSCR;
    alu_op      = OP_MOV;
    immediate_p = 1'b0;
    immediate   = '0;
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_FIN);
    unique case (state_q)
      ST_LD_A: begin
        immediate_p = 1'b1;
        immediate   = a_q;
        dest_reg    = RA;
      end
      ST_LD_B: begin
        immediate_p = 1'b1;
        immediate   = b_q;
        dest_reg    = RB;
      end
      ST_CMP: begin
        alu_op = OP_CMP;
        a_reg  = RA;
        b_reg  = RB;
      end
      ST_STEP: begin
        if (flag_z) begin
          // Route RA onto alu_bus so the result is captured this cycle.
          b_reg = RA;
        end else if (!at_limit) begin
          alu_op = OP_SUB;
          if (flag_l) begin
            a_reg    = RB;
            b_reg    = RA;
            dest_reg = RB;
          end else begin
            a_reg    = RA;
            b_reg    = RB;
            dest_reg = RA;
          end
        end
      end
      default: ;
    endcase
  end

  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer driving two alu_regfile instances: a default build
// and a MAX_ITER=4 build, checked against a reference GCD scoreboard.
module tb_gcd_sequencer;
  import alu_pkg::*;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start0, start1;
  logic [15:0] op_a, op_b;

  logic        busy0, done0, err0, imm_p0;
  logic [15:0] result0, imm0, bus0;
  logic [2:0]  ar0, br0, dr0;
  logic [7:0]  aop0;
  logic [4:0]  flags0;

  logic        busy1, done1, err1, imm_p1;
  logic [15:0] result1, imm1, bus1;
  logic [2:0]  ar1, br1, dr1;
  logic [7:0]  aop1;
  logic [4:0]  flags1;

  int n_total = 0;
  int n_pass  = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  gcd_sequencer u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .op_a(op_a), .op_b(op_b),
    .busy(busy0), .done(done0), .result(result0), .err(err0),
    .a_reg(ar0), .b_reg(br0), .dest_reg(dr0), .immediate(imm0),
    .immediate_p(imm_p0), .alu_op(aop0), .alu_bus(bus0), .flags(flags0)
  );

  alu_regfile u_rf0 (
    .clk(clk), .reset(reset), .a_reg(ar0), .b_reg(br0), .dest_reg(dr0),
    .immediate(imm0), .immediate_p(imm_p0), .alu_op(aop0),
    .alu_bus(bus0), .flags(flags0)
  );

  gcd_sequencer #(.MAX_ITER(4)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .op_a(op_a), .op_b(op_b),
    .busy(busy1), .done(done1), .result(result1), .err(err1),
    .a_reg(ar1), .b_reg(br1), .dest_reg(dr1), .immediate(imm1),
    .immediate_p(imm_p1), .alu_op(aop1), .alu_bus(bus1), .flags(flags1)
  );

  alu_regfile u_rf1 (
    .clk(clk), .reset(reset), .a_reg(ar1), .b_reg(br1), .dest_reg(dr1),
    .immediate(imm1), .immediate_p(imm_p1), .alu_op(aop1),
    .alu_bus(bus1), .flags(flags1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: subtractive Euclid with an abort after max_iter subtractions.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int max_iter);
    exp_t e;
    logic [15:0] x, y;
    int k;
    x = a;
    y = b;
    k = 0;
    e.err = 1'b0;
    if (a == 16'd0 || b == 16'd0) begin
      e.res = a | b;
      e.lat = 1;
      return e;
    end
    while (x != y) begin
      if (k == max_iter) begin
        e.err = 1'b1;
        e.res = 16'd0;
        e.lat = 3 + 2 * (k + 1);
        return e;
      end
      if (x < y) y = y - x;
      else       x = x - y;
      k++;
    end
    e.res = x;
    e.lat = 3 + 2 * (k + 1);
    return e;
  endfunction

  function automatic logic [52:0] outs0();
    return {busy0, done0, err0, result0, ar0, br0, dr0, imm0, imm_p0, aop0};
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  // Drives one start, waits for done (bounded), then checks the scoreboard head.
  // poke > 0 re-asserts start with other operands in that busy cycle.
  task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input int poke, input string tag);
    exp_t e;
    int n;
    logic d, bz, er;
    logic [15:0] r;
    sb_q.push_back(model(a, b, (sel == 0) ? 65535 : 4));
    @(negedge clk);
    op_a = a;
    op_b = b;
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, 1'b0);
    n = 1;
    d = (sel == 0) ? done0 : done1;
    while (!d && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == poke) begin
        op_a = 16'd6;
        op_b = 16'd4;
        set_start(sel, 1'b1);
      end else begin
        set_start(sel, 1'b0);
      end
      d = (sel == 0) ? done0 : done1;
    end
    set_start(sel, 1'b0);
    e  = sb_q.pop_front();
    r  = (sel == 0) ? result0 : result1;
    er = (sel == 0) ? err0 : err1;
    check({tag, " latency"}, 64'(n), 64'(e.lat));
    check({tag, " result"}, 64'(r), 64'(e.res));
    check({tag, " err"}, 64'(er), 64'(e.err));
    @(posedge clk);
    #1;
    d  = (sel == 0) ? done0 : done1;
    bz = (sel == 0) ? busy0 : busy1;
    check({tag, " done/busy drop"}, 64'({d, bz}), 64'(2'b00));
  endtask

  initial begin
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    op_a   = '0;
    op_b   = '0;
    #12;
    check("reset outputs", 64'(outs0()),
          64'({1'b0, 1'b0, 1'b0, 16'd0, 3'd7, 3'd7, 3'd7, 16'd0, 1'b0, OP_MOV}));
    @(negedge clk);
    reset = 1'b0;

    run_op(0, 16'd12, 16'd8, 0, "gcd 12/8");
    check("12/8 RA", 64'(u_rf0.regs_q[1]), 64'd4);
    check("12/8 RB", 64'(u_rf0.regs_q[2]), 64'd4);

    run_op(0, 16'd8, 16'd12, 0, "gcd 8/12");

    run_op(0, 16'd0, 16'd35, 0, "gcd 0/35");
    check("0/35 RA untouched", 64'(u_rf0.regs_q[1]), 64'd4);
    check("0/35 RB untouched", 64'(u_rf0.regs_q[2]), 64'd4);

    run_op(0, 16'd0, 16'd0, 0, "gcd 0/0");

    run_op(0, 16'hFFFF, 16'hFFFF, 0, "gcd ffff/ffff");

    run_op(1, 16'd100, 16'd1, 3, "limit 100/1");
    repeat (2) @(posedge clk);
    #1;
    check("limit start not queued", 64'({busy1, err1, result1}), 64'({1'b0, 1'b1, 16'd0}));

    // Abort a 21/13 run in its first STEP with an asynchronous reset.
    @(negedge clk);
    op_a   = 16'd21;
    op_b   = 16'd13;
    start0 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("21/13 STEP drive", 64'({busy0, ar0, br0, dr0, aop0}),
          64'({1'b1, 3'd1, 3'd2, 3'd1, OP_SUB}));
    #2;
    reset = 1'b1;
    #1;
    check("async reset outputs", 64'(outs0()),
          64'({1'b0, 1'b0, 1'b0, 16'd0, 3'd7, 3'd7, 3'd7, 16'd0, 1'b0, OP_MOV}));
    @(negedge clk);
    reset = 1'b0;

    run_op(0, 16'd21, 16'd13, 0, "gcd 21/13");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
